mem_access_ctrl: RTL and testbench

- MEM-stage controller between the EX/MEM pipeline register and an external word-addressed data memory with a req/ack handshake.
- Turns the registered MemRead/MemWrite/address/write-data into a memory transaction.
- Holds the pipeline via stall_o, which drives hold_i of all pipeline registers, until the access completes.
- Supplies read data to MEM/WB. A single-entry read buffer gives zero-stall repeated loads.

---
 rtl/mem_ctrl_pkg.sv | 26 ++
 rtl/mem_access_ctrl_if.sv | 38 +++
 rtl/mem_read_buffer.sv | 58 +++++
 rtl/mem_access_ctrl.sv | 156 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the MEM-stage memory access controller:
//   - state_e      : controller FSM encoding (IDLE / ACCESS / DONE)
//   - DEFAULT_*    : default timeout length and error read value
//   - TAG_W        : width of the word tag held by the read buffer
//   - word_align() : byte address -> word-aligned byte address
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int          DEFAULT_TIMEOUT  = 16;
    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

    // Word tag = byte address without the two byte-select bits.
    localparam int TAG_W = 30;

    // Memory is word addressed, so the byte-select bits are forced to zero.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
// Request/acknowledge bus between the MEM-stage controller and the
// external word-addressed data memory.
//   mem_req   : request, held high for the whole access
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : word-aligned byte address
//   mem_wdata : store data
//   mem_ack   : one-cycle completion pulse from memory
//   mem_rdata : load data, valid together with mem_ack
// Modports: master = controller side, slave = memory side.
interface mem_access_ctrl_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/mem_read_buffer.sv
// mem_read_buffer
// Single-entry load buffer (valid / word tag / data) that lets a repeated
// load of the same word complete without a memory access.
//   clk_i, rst_i  : clock, asynchronous active-low reset (invalidates entry)
//   lookup_tag_i  : tag of the current load, compared combinationally
//   hit_o, data_o : hit flag and buffered word
//   upd_tag_i     : tag of the access being completed
//   fill_i        : read completed, allocate entry with fill_data_i
//   wr_i          : write completed, refresh data with wr_data_i on tag hit
module mem_read_buffer
    import mem_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [TAG_W-1:0] lookup_tag_i,
    output logic             hit_o,
    output logic [31:0]      data_o,
    input  logic [TAG_W-1:0] upd_tag_i,
    input  logic             fill_i,
    input  logic [31:0]      fill_data_i,
    input  logic             wr_i,
    input  logic [31:0]      wr_data_i
);

    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q,   tag_d;
    logic [31:0]      data_q,  data_d;

    assign hit_o  = valid_q && (tag_q == lookup_tag_i);
    assign data_o = data_q;

    // A write never allocates; it only keeps an existing entry coherent.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_i) begin
            valid_d = 1'b1;
            tag_d   = upd_tag_i;
            data_d  = fill_data_i;
        end else if (wr_i && valid_q && (tag_q == upd_tag_i)) begin
            data_d  = wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// MEM-stage controller: turns the EX/MEM MemRead/MemWrite request into a
// req/ack memory transaction, holds the pipeline while it is in flight and
// returns load data to MEM/WB. A one-entry read buffer serves repeated loads
// of the same word without stalling.
//   clk_i, rst_i          : clock, asynchronous active-low reset
//   MemRead_i, MemWrite_i : load / store request (store has priority)
//   addr_i, wdata_i       : byte address and store data
//   rdata_o               : load data
//   stall_o               : pipeline hold
//   err_o                 : sticky access-timeout flag
//   mem                   : memory bus (master side)
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int          TIMEOUT  = DEFAULT_TIMEOUT,
    parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      MemRead_i,
    input  logic                      MemWrite_i,
    input  logic [31:0]               addr_i,
    input  logic [31:0]               wdata_i,
    output logic [31:0]               rdata_o,
    output logic                      stall_o,
    output logic                      err_o,
    mem_access_ctrl_if.master         mem
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               err_q,   err_d;
    logic               req_q,   req_d;
    logic               we_q,    we_d;
    logic [31:0]        addr_q,  addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               stall_c;
    logic               buf_hit;
    logic [31:0]        buf_data;
    logic               buf_fill;
    logic               buf_wr;

    mem_read_buffer u_read_buffer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .lookup_tag_i (addr_i[31:2]),
        .hit_o        (buf_hit),
        .data_o       (buf_data),
        .upd_tag_i    (addr_q[31:2]),
        .fill_i       (buf_fill),
        .fill_data_i  (mem.mem_rdata),
        .wr_i         (buf_wr),
        .wr_data_i    (wdata_q)
    );

    // Next-state and output logic. In IDLE the stall is raised in the same
    // cycle the miss/write is seen so the pipeline never advances past it.
    // In ACCESS an ack takes precedence over the timeout on the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        stall_c  = 1'b0;
        rdata_o  = rdata_q;
        buf_fill = 1'b0;
        buf_wr   = 1'b0;

        case (state_q)
            IDLE: begin
                if (MemWrite_i || (MemRead_i && !buf_hit)) begin
                    stall_c = 1'b1;
                    addr_d  = word_align(addr_i);
                    we_d    = MemWrite_i;
                    wdata_d = wdata_i;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ACCESS;
                end else if (MemRead_i) begin
                    rdata_o = buf_data;
                end
            end

            ACCESS: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (mem.mem_ack) begin
                    if (!we_q) begin
                        rdata_d  = mem.mem_rdata;
                        buf_fill = 1'b1;
                    end else begin
                        buf_wr   = 1'b1;
                    end
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = ERR_DATA;
                    end
                    req_d   = 1'b0;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The IDLE stall is combinational from the request inputs, so it must
    // be masked while reset is asserted.
    assign stall_o       = stall_c & rst_i;
    assign err_o         = err_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Scoreboard bench for mem_access_ctrl. Each issued load/store pushes its
// expected outcome; a monitor pops it when the instruction leaves the MEM
// stage (request present, stall_o low) and checks stall length, request
// cycles, bus address/we/wdata, rdata_o and err_o. A memory responder
// acknowledges on a programmed ACCESS cycle.
module tb_mem_access_ctrl;

    typedef struct {
        logic        isRead;
        logic [31:0] expRdata;
        int          expStall;
        logic [31:0] expAddr;
        logic        expWe;
        logic [31:0] expWdata;
        logic        expErr;
    } expRec_t;

    logic        clk;
    logic        rstN;
    logic        memRead;
    logic        memWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    int          assertCount;
    int          failCount;
    expRec_t     sb[$];

    int          ackDelay;
    logic [31:0] ackData;
    logic        forceAck;
    logic [31:0] forceData;

    mem_access_ctrl_if memBus ();

    mem_access_ctrl dut (
        .clk_i      (clk),
        .rst_i      (rstN),
        .MemRead_i  (memRead),
        .MemWrite_i (memWrite),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .stall_o    (stall),
        .err_o      (err),
        .mem        (memBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic flagFail(input string name);
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s at %0t", name, $time);
    endtask

    // Memory model: ack on the ackDelay-th request cycle (0 = never), or a
    // single stray ack when forceAck is set.
    initial begin
        int reqSeen;
        reqSeen = 0;
        memBus.mem_ack   = 1'b0;
        memBus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (forceAck) begin
                memBus.mem_ack   = 1'b1;
                memBus.mem_rdata = forceData;
                forceAck         = 1'b0;
            end else if (memBus.mem_req) begin
                reqSeen++;
                if (reqSeen == ackDelay) begin
                    memBus.mem_ack   = 1'b1;
                    memBus.mem_rdata = ackData;
                end else begin
                    memBus.mem_ack   = 1'b0;
                end
            end else begin
                reqSeen        = 0;
                memBus.mem_ack = 1'b0;
            end
        end
    end

    // Monitor: bus checks on every request cycle, full check on retirement.
    initial begin
        int      stallCnt;
        int      reqCnt;
        expRec_t e;
        stallCnt = 0;
        reqCnt   = 0;
        forever begin
            @(negedge clk);
            if (!rstN) begin
                stallCnt = 0;
                reqCnt   = 0;
            end else begin
                if (memBus.mem_req) begin
                    reqCnt++;
                    if (sb.size() == 0) begin
                        flagFail("unexpected_mem_req");
                    end else begin
                        checkOutput("mem_addr", memBus.mem_addr, sb[0].expAddr);
                        checkOutput("mem_we", {31'b0, memBus.mem_we}, {31'b0, sb[0].expWe});
                        if (sb[0].expWe)
                            checkOutput("mem_wdata", memBus.mem_wdata, sb[0].expWdata);
                    end
                end
                if (stall) begin
                    stallCnt++;
                end else if (memRead || memWrite) begin
                    if (sb.size() == 0) begin
                        flagFail("retire_without_expectation");
                    end else begin
                        e = sb.pop_front();
                        checkOutput("stall_cycles", stallCnt, e.expStall);
                        checkOutput("req_cycles", reqCnt,
                                    (e.expStall == 0) ? 0 : e.expStall - 1);
                        if (e.isRead)
                            checkOutput("rdata", rdata, e.expRdata);
                        checkOutput("err", {31'b0, err}, {31'b0, e.expErr});
                    end
                    stallCnt = 0;
                    reqCnt   = 0;
                end
            end
        end
    end

    // Issue one instruction and hold it until the pipeline would advance.
    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input int delay, input logic [31:0] ackWord,
                                 input int expStall, input logic [31:0] expRdata,
                                 input logic [31:0] expAddr, input logic expErr);
        expRec_t e;
        int      budget;
        e.isRead   = rd && !wr;
        e.expRdata = expRdata;
        e.expStall = expStall;
        e.expAddr  = expAddr;
        e.expWe    = wr;
        e.expWdata = wd;
        e.expErr   = expErr;
        sb.push_back(e);
        ackDelay = delay;
        ackData  = ackWord;
        memRead  = rd;
        memWrite = wr;
        addr     = a;
        wdata    = wd;
        budget   = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (stall && budget < 200);
        if (stall) flagFail("stall_never_released");
        @(posedge clk);
        #1;
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

    initial begin
        int budget;
        assertCount = 0;
        failCount   = 0;
        ackDelay    = 0;
        ackData     = '0;
        forceAck    = 1'b0;
        forceData   = '0;
        rstN        = 1'b0;
        memRead     = 1'b1;
        memWrite    = 1'b0;
        addr        = 32'h100;
        wdata       = '0;

        #12;
        checkOutput("reset_stall", {31'b0, stall}, 32'd0);
        checkOutput("reset_req", {31'b0, memBus.mem_req}, 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
        checkOutput("reset_err", {31'b0, err}, 32'd0);
        memRead = 1'b0;
        #5 rstN = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("idle_stall", {31'b0, stall}, 32'd0);
            checkOutput("idle_req", {31'b0, memBus.mem_req}, 32'd0);
            checkOutput("idle_err", {31'b0, err}, 32'd0);
            checkOutput("idle_rdata", rdata, 32'd0);
        end
        @(posedge clk);
        #1;

        //            rd    wr    addr     wdata          dly ackWord        stl rdata          expAddr  err
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0,         3,  32'h12345678,  4,  32'h12345678,  32'h100, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h103, 32'h0,         0,  32'h0,         0,  32'h12345678,  32'h100, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h100, 32'hCAFEF00D,  1,  32'h0,         2,  32'h0,         32'h100, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0,         0,  32'h0,         0,  32'hCAFEF00D,  32'h100, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h402, 32'h0A0B0C0D,  1,  32'h0,         2,  32'h0,         32'h400, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h101, 32'h0,         0,  32'h0,         0,  32'hCAFEF00D,  32'h100, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h500, 32'h0,         16, 32'h600DD00D,  17, 32'h600DD00D,  32'h500, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h200, 32'h0,         0,  32'h0,         17, 32'hDEADBEEF,  32'h200, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h200, 32'h0,         2,  32'h55AA55AA,  3,  32'h55AA55AA,  32'h200, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h600, 32'h13579BDF,  2,  32'h0,         3,  32'h0,         32'h600, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h600, 32'h0,         1,  32'h77777777,  2,  32'h77777777,  32'h600, 1'b1);

        // Reset during ACCESS, followed by a stray ack after release.
        begin
            expRec_t e;
            e.isRead   = 1'b1;
            e.expRdata = '0;
            e.expStall = 0;
            e.expAddr  = 32'h300;
            e.expWe    = 1'b0;
            e.expWdata = '0;
            e.expErr   = 1'b1;
            sb.push_back(e);
        end
        ackDelay = 0;
        memRead  = 1'b1;
        addr     = 32'h300;
        budget   = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!memBus.mem_req && budget < 10);
        if (!memBus.mem_req) flagFail("reset_test_no_request");
        repeat (2) @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        checkOutput("req_drop_on_reset", {31'b0, memBus.mem_req}, 32'd0);
        checkOutput("stall_in_reset", {31'b0, stall}, 32'd0);
        checkOutput("err_cleared_by_reset", {31'b0, err}, 32'd0);
        sb.delete();
        memRead = 1'b0;
        @(negedge clk);
        #2 rstN = 1'b1;
        forceData = 32'hBAADBAAD;
        forceAck  = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("late_ack_req", {31'b0, memBus.mem_req}, 32'd0);
        checkOutput("late_ack_stall", {31'b0, stall}, 32'd0);
        checkOutput("late_ack_err", {31'b0, err}, 32'd0);
        @(posedge clk);
        #1;

        // The buffer was invalidated, so 0x200 must miss again.
        applyStimulus(1'b1, 1'b0, 32'h200, 32'h0,         1,  32'h0BADF00D,  2,  32'h0BADF00D,  32'h200, 1'b0);

        repeat (2) @(negedge clk);
        if (sb.size() != 0) flagFail("scoreboard_not_drained");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

endmodule
